// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Holds the program counter, presents
//               it as the instruction-memory address, and loads the IF/ID
//               buffer with PC+1 and the fetched instruction. A taken branch
//               redirects the PC and flushes the buffer (one bubble).
//               Optional halt detection: define IF_HALT_DETECT_EN to stop
//               fetch on HALT_WORD until a taken branch resumes it.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter int          AW        = 6,
    parameter int          IW        = 16,
    parameter logic [IW-1:0] HALT_WORD = {IW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] in_branch_target,
    input  logic          in_branch_taken,
    input  logic          in_stall,
    input  logic [IW-1:0] in_imem_data,
    output logic [AW-1:0] out_imem_addr,
    output logic [AW-1:0] out_pc1,
    output logic [IW-1:0] out_instr,
    output logic          out_valid,
    output logic          out_halted
);

`ifdef IF_HALT_DETECT_EN
    localparam logic c_HALT_EN = 1'b1;
`else
    localparam logic c_HALT_EN = 1'b0;
`endif

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] r_pc1;
    logic [AW-1:0] w_pc1_next;
    logic [IW-1:0] r_instr;
    logic [IW-1:0] w_instr_next;
    logic          r_valid;
    logic          w_valid_next;
    logic [AW-1:0] w_pc_inc;
    logic          w_halt_hit;

    // Sequential increment wraps naturally at 2^AW (carry is discarded).
    assign w_pc_inc   = r_pc + AW'(1);
    // Halt match only counts when detection is compiled in.
    assign w_halt_hit = c_HALT_EN & (in_imem_data == HALT_WORD);

    // State and IF/ID buffer registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_pc    <= '0;
            r_pc1   <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_pc1   <= w_pc1_next;
            r_instr <= w_instr_next;
            r_valid <= w_valid_next;
        end
    end

    // Next-state logic: branch redirect beats stall; HALT ignores stall.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pc1_next   = r_pc1;
        w_instr_next = r_instr;
        w_valid_next = r_valid;
        case (r_state)
            S_RUN: begin
                if (in_branch_taken) begin
                    w_pc_next    = in_branch_target;
                    w_valid_next = 1'b0;
                end else if (!in_stall) begin
                    w_pc_next    = w_pc_inc;
                    w_pc1_next   = w_pc_inc;
                    w_instr_next = in_imem_data;
                    w_valid_next = 1'b1;
                    // The halt word itself is buffered as a valid instruction.
                    if (w_halt_hit) begin
                        w_state_next = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (in_branch_taken) begin
                    // Halt was fetched down a wrong path; resume at target.
                    w_pc_next    = in_branch_target;
                    w_valid_next = 1'b0;
                    w_state_next = S_RUN;
                end else begin
                    w_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    assign out_imem_addr = r_pc;
    assign out_pc1       = r_pc1;
    assign out_instr     = r_instr;
    assign out_valid     = r_valid;

`ifdef IF_HALT_DETECT_EN
    assign out_halted = (r_state == S_HALT);
`else
    assign out_halted = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage. Directed scenarios
//               followed by randomized branch/stall/reset traffic, compared
//               against a behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

`ifdef IF_HALT_DETECT_EN
    localparam bit c_HALT_EN = 1'b1;
`else
    localparam bit c_HALT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  in_branch_target;
    logic        in_branch_taken;
    logic        in_stall;
    logic [15:0] in_imem_data;
    logic [5:0]  out_imem_addr;
    logic [5:0]  out_pc1;
    logic [15:0] out_instr;
    logic        out_valid;
    logic        out_halted;

    logic [15:0] mem [64];

    int checks;
    int failures;

    // Behavioural model state
    int          m_pc;
    int          m_pc1;
    logic [15:0] m_instr;
    bit          m_valid;
    bit          m_halted;

    if_fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_branch_target (in_branch_target),
        .in_branch_taken  (in_branch_taken),
        .in_stall         (in_stall),
        .in_imem_data     (in_imem_data),
        .out_imem_addr    (out_imem_addr),
        .out_pc1          (out_pc1),
        .out_instr        (out_instr),
        .out_valid        (out_valid),
        .out_halted       (out_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory
    assign in_imem_data = mem[out_imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock edge of the fetch rules to the model.
    task automatic model_edge(input bit r, input bit br, input int tgt, input bit st);
        if (r) begin
            m_pc = 0; m_pc1 = 0; m_instr = 16'h0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_valid = 0;
            if (br) begin
                m_pc = tgt;
                m_halted = 0;
            end
        end else if (br) begin
            m_pc = tgt;
            m_valid = 0;
        end else if (!st) begin
            m_instr = mem[m_pc];
            m_pc    = (m_pc + 1) % 64;
            m_pc1   = m_pc;
            m_valid = 1;
            if (c_HALT_EN && m_instr == 16'hFFFF) m_halted = 1;
        end
    endtask

    task automatic compare_all();
        check("addr",   32'(out_imem_addr), 32'(m_pc));
        check("pc1",    32'(out_pc1),       32'(m_pc1));
        check("instr",  32'(out_instr),     32'(m_instr));
        check("valid",  32'(out_valid),     32'(m_valid));
        check("halted", 32'(out_halted),    32'(m_halted));
    endtask

    // Drive inputs (called just after a falling edge), take one rising edge,
    // update the model, then sample on the following falling edge.
    task automatic step(input bit r, input bit br, input int tgt, input bit st);
        rst              = r;
        in_branch_taken  = br;
        in_branch_target = 6'(tgt);
        in_stall         = st;
        @(posedge clk);
        model_edge(r, br, tgt, st);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_pc = 0; m_pc1 = 0; m_instr = 16'h0; m_valid = 0; m_halted = 0;
        rst = 1'b1; in_branch_taken = 1'b0; in_branch_target = 6'd0; in_stall = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        @(negedge clk);

        // Reset, with noisy inputs that must be ignored
        step(1, 1, 17, 1);
        step(1, 0, 0, 0);
        check("rst_addr",  32'(out_imem_addr), 32'd0);
        check("rst_valid", 32'(out_valid),     32'd0);

        // Free run three edges
        repeat (3) step(0, 0, 0, 0);
        check("run_addr",  32'(out_imem_addr), 32'd3);
        check("run_pc1",   32'(out_pc1),       32'd3);
        check("run_instr", 32'(out_instr),     32'h0102);
        check("run_valid", 32'(out_valid),     32'd1);

        // Branch at pc=5 to 24
        repeat (2) step(0, 0, 0, 0);
        check("pre_br_addr", 32'(out_imem_addr), 32'd5);
        step(0, 1, 24, 0);
        check("br_valid", 32'(out_valid),     32'd0);
        check("br_addr",  32'(out_imem_addr), 32'd24);
        step(0, 0, 0, 0);
        check("br_pc1",   32'(out_pc1),   32'd25);
        check("br_instr", 32'(out_instr), 32'h0118);
        check("br_valid2", 32'(out_valid), 32'd1);

        // Stall at pc=10 for 3 cycles, then stall together with branch
        step(0, 1, 9, 0);
        step(0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1);
        check("stall_addr",  32'(out_imem_addr), 32'd10);
        check("stall_instr", 32'(out_instr),     32'h0109);
        check("stall_pc1",   32'(out_pc1),       32'd10);
        step(0, 1, 2, 1);
        check("stbr_addr",  32'(out_imem_addr), 32'd2);
        check("stbr_valid", 32'(out_valid),     32'd0);

        // Consecutive taken branches keep the bubble
        step(0, 1, 40, 0);
        step(0, 1, 41, 0);
        check("dbl_addr",  32'(out_imem_addr), 32'd41);
        check("dbl_valid", 32'(out_valid),     32'd0);

        // Wrap-around from 62
        step(0, 1, 62, 0);
        step(0, 0, 0, 0);
        check("wrap_pc1a", 32'(out_pc1), 32'd63);
        check("wrap_addr_a", 32'(out_imem_addr), 32'd63);
        step(0, 0, 0, 0);
        check("wrap_pc1b", 32'(out_pc1), 32'd0);
        check("wrap_addr_b", 32'(out_imem_addr), 32'd0);
        step(0, 0, 0, 0);
        check("wrap_pc1c", 32'(out_pc1), 32'd1);

        // Halt word at address 7
        mem[7] = 16'hFFFF;
        step(0, 1, 6, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("halt_instr", 32'(out_instr), 32'hFFFF);
        check("halt_valid", 32'(out_valid), 32'd1);
        check("halt_flag",  32'(out_halted), 32'(c_HALT_EN));
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        if (c_HALT_EN) begin
            check("halt_hold_addr",  32'(out_imem_addr), 32'd8);
            check("halt_hold_valid", 32'(out_valid),     32'd0);
        end else begin
            check("nohalt_addr",  32'(out_imem_addr), 32'd9);
            check("nohalt_flag",  32'(out_halted),    32'd0);
        end
        step(0, 1, 3, 0);
        check("resume_flag", 32'(out_halted), 32'd0);
        check("resume_addr", 32'(out_imem_addr), 32'd3);
        step(0, 0, 0, 0);
        check("resume_instr", 32'(out_instr), 32'h0103);
        mem[7] = 16'h0107;

        // Reset during a stall at pc=20
        step(0, 1, 19, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("mid_addr", 32'(out_imem_addr), 32'd20);
        step(1, 0, 0, 1);
        check("mid_rst_addr",  32'(out_imem_addr), 32'd0);
        check("mid_rst_pc1",   32'(out_pc1),       32'd0);
        check("mid_rst_instr", 32'(out_instr),     32'd0);
        check("mid_rst_valid", 32'(out_valid),     32'd0);

        // Randomized traffic
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
        for (int n = 0; n < 600; n++) begin
            bit r, br, st;
            r  = ($urandom_range(0, 59) == 0);
            br = ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 3) == 0);
            if (n % 97 == 0) mem[$urandom_range(0, 63)] = 16'($urandom);
            step(r, br, int'($urandom_range(0, 63)), st);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
